rst_seq_ml: RTL and testbench

Parametrised power-on and soft reset sequencer for the sensor capture pipeline. It holds every downstream domain in reset for a programmable settle time after power-up. It then releases `NUM_CH` active-low reset outputs one at a time, at a fixed spacing, so the sensor, capture and VDMA stages come up in order. It extends the single fixed-count power-on reset generator with multiple channels, staggered release, soft re-reset and a completion flag.

---
 rtl/rst_seq_pkg.sv | 32 +++
 rtl/rst_seq_ml_if.sv | 21 ++
 rtl/rst_seq_filt.sv | 31 +++
 rtl/rst_seq_ml.sv | 142 ++++++++++++++
 tb/tb_rst_seq_ml.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the staggered reset sequencer: FSM state
// encoding, a clog2 helper and the legal parameter ranges checked at elaboration.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_SEQ  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam int unsigned NUM_CH_MIN = 1;
    localparam int unsigned NUM_CH_MAX = 16;
    localparam int unsigned CNT_W_MIN  = 1;
    localparam int unsigned CNT_W_MAX  = 31;
    localparam int unsigned FILT_MIN   = 1;

    // Ceiling log2; clog2(1) == 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((64'd1 << res) < 64'(value)) begin
            res = res + 1;
        end
        return res;
    endfunction

    // A hold/step count must be nonzero and representable in the counter.
    function automatic bit cnt_in_range(input int unsigned value, input int unsigned width);
        return (value >= 1) && (64'(value) < (64'd1 << width));
    endfunction

endpackage

// File: rtl/rst_seq_ml_if.sv
// Soft-request input and reset/done outputs of the reset sequencer, grouped
// so the controller side (master) and the sequencer (slave) share one bundle.
interface rst_seq_ml_if #(
    parameter int unsigned NUM_CH = 3
);
    logic              soft_rst_i;
    logic [NUM_CH-1:0] rst_n_o;
    logic              done_o;

    modport master (
        output soft_rst_i,
        input  rst_n_o,
        input  done_o
    );

    modport slave (
        input  soft_rst_i,
        output rst_n_o,
        output done_o
    );
endinterface

// File: rtl/rst_seq_filt.sv
// Soft-request debounce: accepts a request on the FILT-th consecutive high
// sample and only once per high run; any low sample clears the count.
module rst_seq_filt
    import rst_seq_pkg::*;
#(
    parameter int unsigned FILT = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic req_i,
    output logic acc_o
);

    localparam int unsigned FW = clog2(FILT + 1);

    logic [FW-1:0] cnt_q;

    // The count saturates at FILT, so a held request cannot re-trigger.
    assign acc_o = req_i && (cnt_q == FW'(FILT - 1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else if (!req_i) begin
            cnt_q <= '0;
        end else if (cnt_q != FW'(FILT)) begin
            cnt_q <= cnt_q + FW'(1);
        end
    end

endmodule

// File: rtl/rst_seq_ml.sv
// Power-on / soft reset sequencer: holds all channels, then releases them one
// by one at STEP spacing. Build with RST_SEQ_SOFT_FILT_EN to debounce soft_rst_i.
module rst_seq_ml
    import rst_seq_pkg::*;
#(
    parameter int unsigned CNT_W    = 20,
    parameter int unsigned NUM_CH   = 3,
    parameter int unsigned HOLD_CNT = 20'hffff0,
    parameter int unsigned SOFT_CNT = 256,
    parameter int unsigned STEP     = 16,
    parameter int unsigned FILT     = 4
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    rst_seq_ml_if.slave  bus
);

    localparam int unsigned      CH_W      = clog2(NUM_CH) + 1;
    localparam logic [CNT_W-1:0] HOLD_LEN  = CNT_W'(HOLD_CNT);
    localparam logic [CNT_W-1:0] SOFT_LEN  = CNT_W'(SOFT_CNT);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP - 1);
    localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NUM_CH - 1);

    if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX) begin : g_bad_num_ch
        $error("rst_seq_ml: NUM_CH out of range");
    end
    if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
        $error("rst_seq_ml: CNT_W out of range");
    end
    if (!cnt_in_range(HOLD_CNT, CNT_W) || !cnt_in_range(SOFT_CNT, CNT_W)
        || !cnt_in_range(STEP, CNT_W)) begin : g_bad_cnt
        $error("rst_seq_ml: HOLD_CNT/SOFT_CNT/STEP out of range");
    end
    if (FILT < FILT_MIN) begin : g_bad_filt
        $error("rst_seq_ml: FILT out of range");
    end

    logic soft_acc;

`ifdef RST_SEQ_SOFT_FILT_EN
    rst_seq_filt #(
        .FILT (FILT)
    ) u_filt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .req_i   (bus.soft_rst_i),
        .acc_o   (soft_acc)
    );
`else
    assign soft_acc = bus.soft_rst_i;
`endif

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [CNT_W-1:0]  hold_len_q, hold_len_d;
    logic [NUM_CH-1:0] rst_q, rst_d;
    logic              done_q, done_d;

    // NOTE: every target is given its current value first, so no path through
    // this block can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ch_d       = ch_q;
        hold_len_d = hold_len_q;
        rst_d      = rst_q;
        done_d     = done_q;

        if (soft_acc) begin
            // A soft request outranks any release completing this cycle.
            state_d    = ST_HOLD;
            cnt_d      = '0;
            ch_d       = '0;
            hold_len_d = SOFT_LEN;
            rst_d      = '0;
            done_d     = 1'b0;
        end else begin
            unique case (state_q)
                ST_HOLD: begin
                    if (cnt_q == hold_len_q - CNT_W'(1)) begin
                        cnt_d    = '0;
                        rst_d[0] = 1'b1;
                        if (NUM_CH == 1) begin
                            state_d = ST_RUN;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_SEQ;
                            ch_d    = CH_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_SEQ: begin
                    if (cnt_q == STEP_LAST) begin
                        cnt_d = '0;
                        ch_d  = ch_q + CH_W'(1);
                        for (int k = 0; k < NUM_CH; k++) begin
                            if (ch_q == CH_W'(k)) rst_d[k] = 1'b1;
                        end
                        if (ch_q == CH_LAST) begin
                            state_d = ST_RUN;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                end
                default: begin
                    state_d = ST_HOLD;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values and the update order inside the block is irrelevant.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_HOLD;
            cnt_q      <= '0;
            ch_q       <= '0;
            hold_len_q <= HOLD_LEN;
            rst_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ch_q       <= ch_d;
            hold_len_q <= hold_len_d;
            rst_q      <= rst_d;
            done_q     <= done_d;
        end
    end

    assign bus.rst_n_o = rst_q;
    assign bus.done_o  = done_q;

endmodule

// File: tb/tb_rst_seq_ml.sv
// Scoreboard bench for rst_seq_ml: stimulus queues expected output changes,
// a negedge monitor pops and compares them whenever the outputs change.
module tb_rst_seq_ml;

    localparam int NC = 3;
`ifdef RST_SEQ_SOFT_FILT_EN
    localparam int SOFT_NEED = 4;
`else
    localparam int SOFT_NEED = 1;
`endif

    typedef struct {
        int            edge_n;
        logic [NC-1:0] rst;
        logic          done;
    } exp_t;

    logic clk_i   = 1'b0;
    logic rst_n_i = 1'b1;
    logic rst1_n  = 1'b1;
    int   edge_no;
    int   checks  = 0;
    int   errors  = 0;
    exp_t sb_q[$];
    logic [NC:0] prev = '0;

    always #5 clk_i = ~clk_i;

    rst_seq_ml_if #(.NUM_CH(NC)) bus0 ();
    rst_seq_ml_if #(.NUM_CH(1))  bus1 ();

    rst_seq_ml #(
        .CNT_W(20), .NUM_CH(NC), .HOLD_CNT(100), .SOFT_CNT(20), .STEP(8), .FILT(4)
    ) u_dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus0.slave)
    );

    rst_seq_ml #(
        .CNT_W(20), .NUM_CH(1), .HOLD_CNT(1), .SOFT_CNT(20), .STEP(1), .FILT(4)
    ) u_dut1 (
        .clk_i   (clk_i),
        .rst_n_i (rst1_n),
        .bus     (bus1.slave)
    );

    assign bus1.soft_rst_i = 1'b0;

    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) edge_no <= 0;
        else          edge_no <= edge_no + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, exp, edge_no, $time);
        end
    endtask

    task automatic push(input int e, input logic [NC-1:0] r, input logic d);
        exp_t x;
        x.edge_n = e;
        x.rst    = r;
        x.done   = d;
        sb_q.push_back(x);
    endtask

    task automatic wait_edge(input int n);
        while (edge_no < n) @(negedge clk_i);
    endtask

    // Monitor: any output change must match the next queued expectation.
    always @(negedge clk_i) begin
        exp_t e;
        if ({bus0.rst_n_o, bus0.done_o} !== prev) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_change: got rst=%b done=%b at edge %0d, expected no change",
                         bus0.rst_n_o, bus0.done_o, edge_no);
            end else begin
                e = sb_q.pop_front();
                check("change_edge", edge_no, e.edge_n);
                check("change_rst", 32'(bus0.rst_n_o), 32'(e.rst));
                check("change_done", 32'(bus0.done_o), 32'(e.done));
            end
            prev = {bus0.rst_n_o, bus0.done_o};
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        bus0.soft_rst_i = 1'b0;
        #1;
        rst_n_i = 1'b0;
        rst1_n  = 1'b0;
        repeat (3) @(negedge clk_i);
        check("reset_rst", 32'(bus0.rst_n_o), 32'd0);
        check("reset_done", 32'(bus0.done_o), 32'd0);
        check("reset_rst_1ch", 32'(bus1.rst_n_o), 32'd0);

        // Power-on release: 100, 108, 116.
        push(100, 3'b001, 1'b0);
        push(108, 3'b011, 1'b0);
        push(116, 3'b111, 1'b1);
        rst_n_i = 1'b1;
        rst1_n  = 1'b1;
        #1;
        check("pre_edge1_1ch", 32'({bus1.rst_n_o, bus1.done_o}), 32'b00);
        @(posedge clk_i);
        #1;
        check("edge1_rst_1ch", 32'(bus1.rst_n_o), 32'd1);
        check("edge1_done_1ch", 32'(bus1.done_o), 32'd1);
        wait_edge(1116);
        check("static_rst", 32'(bus0.rst_n_o), 32'b111);
        check("static_done", 32'(bus0.done_o), 32'd1);

        // Asynchronous clear from RUN, then again mid-SEQ at edge 104.
        @(negedge clk_i);
        #2;
        push(0, 3'b000, 1'b0);
        rst_n_i = 1'b0;
        #1;
        check("async_clear_run", 32'({bus0.rst_n_o, bus0.done_o}), 32'd0);
        @(negedge clk_i);
        push(100, 3'b001, 1'b0);
        rst_n_i = 1'b1;
        wait_edge(104);
        #2;
        push(0, 3'b000, 1'b0);
        rst_n_i = 1'b0;
        #1;
        check("async_clear_seq", 32'({bus0.rst_n_o, bus0.done_o}), 32'd0);
        @(negedge clk_i);
        push(100, 3'b001, 1'b0);
        push(108, 3'b011, 1'b0);
        push(116, 3'b111, 1'b1);
        rst_n_i = 1'b1;

        // One-cycle soft request sampled at edge 200.
`ifndef RST_SEQ_SOFT_FILT_EN
        push(200, 3'b000, 1'b0);
        push(220, 3'b001, 1'b0);
        push(228, 3'b011, 1'b0);
        push(236, 3'b111, 1'b1);
`endif
        wait_edge(199);
        bus0.soft_rst_i = 1'b1;
        wait_edge(200);
        bus0.soft_rst_i = 1'b0;
        wait_edge(299);

        // High 301..303, low 304, high 305..308.
`ifdef RST_SEQ_SOFT_FILT_EN
        push(308, 3'b000, 1'b0);
`else
        push(301, 3'b000, 1'b0);
`endif
        push(328, 3'b001, 1'b0);
        push(336, 3'b011, 1'b0);
        push(344, 3'b111, 1'b1);
        for (int e = 301; e <= 309; e++) begin
            wait_edge(e - 1);
            bus0.soft_rst_i = ((e >= 301 && e <= 303) || (e >= 305 && e <= 308)) ? 1'b1 : 1'b0;
        end
        wait_edge(360);
        check("after_soft_rst", 32'(bus0.rst_n_o), 32'b111);

        // Soft request accepted on the release edge of channel 1 (edge 108).
        @(negedge clk_i);
        #2;
        push(0, 3'b000, 1'b0);
        rst_n_i = 1'b0;
        @(negedge clk_i);
        push(100, 3'b001, 1'b0);
        push(108, 3'b000, 1'b0);
        push(128, 3'b001, 1'b0);
        push(136, 3'b011, 1'b0);
        push(144, 3'b111, 1'b1);
        rst_n_i = 1'b1;
        for (int e = 109 - SOFT_NEED; e <= 109; e++) begin
            wait_edge(e - 1);
            bus0.soft_rst_i = (e <= 108) ? 1'b1 : 1'b0;
        end
        wait_edge(200);

        check("final_rst", 32'(bus0.rst_n_o), 32'b111);
        check("final_done", 32'(bus0.done_o), 32'd1);
        check("final_1ch", 32'({bus1.rst_n_o, bus1.done_o}), 32'b11);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
